// File: rtl/sort4_ctrl_pkg.sv
// Shared types and constants for the four-entry sort engine.
package sort4_ctrl_pkg;
  localparam int SORT_W = 4;
  localparam int SORT_N = 4;

  localparam logic ORD_ASC  = 1'b0;
  localparam logic ORD_DESC = 1'b1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/sort4_ctrl_if.sv
// Input and output key streams of the sort engine; slave is the engine side.
interface sort4_ctrl_if;
  logic                             in_valid;
  logic                             in_ready;
  logic [sort4_ctrl_pkg::SORT_W-1:0] in_data;
  logic                             in_desc;
  logic                             out_valid;
  logic                             out_ready;
  logic [sort4_ctrl_pkg::SORT_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sort4_ctrl_comp_4bit.sv
// The team's 4-bit magnitude comparator: G2 = P>Q, L2 = P<Q, E2 = P==Q.
module comp_4bit (
  input  logic [3:0] P,
  input  logic [3:0] Q,
  output logic       G2,
  output logic       L2,
  output logic       E2
);
  assign G2 = (P > Q);
  assign L2 = (P < Q);
  assign E2 = (P == Q);
endmodule

// File: rtl/sort4_ctrl.sv
// Four-entry bubble sorter: loads a batch, sorts in place with one shared
// comparator (one compare per cycle), then streams the batch out.
module sort4_ctrl
  import sort4_ctrl_pkg::*;
#(
  parameter int W = SORT_W,
  parameter int N = SORT_N
) (
  input  logic         clk,
  input  logic         rst,
  sort4_ctrl_if.slave  io,
  output logic         busy,
  output logic [2:0]   swap_cnt
);
  localparam int CW = $clog2(N);

  state_t          state, state_n;
  logic [CW-1:0]   ld_cnt, ld_cnt_n;
  logic [CW-1:0]   rd_cnt, rd_cnt_n;
  logic [CW-1:0]   pass, pass_n;
  logic [CW-1:0]   j, j_n, j1;
  logic            swp_pass, swp_pass_n;
  logic            desc, desc_n;
  logic [2:0]      swap_cnt_n;
  logic [W-1:0]    mem   [N];
  logic [W-1:0]    mem_n [N];
  logic            g, l, e;
  logic            dir_hit, do_swap;

  assign j1 = j + CW'(1);

  comp_4bit u_cmp (
    .P  (mem[j]),
    .Q  (mem[j1]),
    .G2 (g),
    .L2 (l),
    .E2 (e)
  );

  assign io.in_ready  = (state == S_LOAD);
  assign io.out_valid = (state == S_DRAIN);
  assign io.out_data  = mem[rd_cnt];
  assign busy         = (state != S_LOAD);

  always_comb begin
    state_n    = state;
    ld_cnt_n   = ld_cnt;
    rd_cnt_n   = rd_cnt;
    pass_n     = pass;
    j_n        = j;
    swp_pass_n = swp_pass;
    desc_n     = desc;
    swap_cnt_n = swap_cnt;
    mem_n      = mem;
    dir_hit    = 1'b0;
    do_swap    = 1'b0;

    case (desc)
      ORD_ASC:  dir_hit = g;
      ORD_DESC: dir_hit = l;
      default:  dir_hit = 1'b0;
    endcase

    case (state)
      S_LOAD: begin
        if (io.in_valid) begin
          mem_n[ld_cnt] = io.in_data;
          ld_cnt_n      = ld_cnt + CW'(1);
          if (ld_cnt == '0) begin
            desc_n     = io.in_desc;
            swap_cnt_n = '0;
          end
          if (ld_cnt == CW'(N - 1)) begin
            pass_n     = '0;
            j_n        = '0;
            swp_pass_n = 1'b0;
            state_n    = S_SORT;
          end
        end
      end

      S_SORT: begin
        do_swap = dir_hit && !e;
        if (do_swap) begin
          mem_n[j]   = mem[j1];
          mem_n[j1]  = mem[j];
          swap_cnt_n = swap_cnt + 3'd1;
          swp_pass_n = 1'b1;
        end
        // Early exit must see this cycle's swap, not only earlier ones in the pass.
        if (j != CW'(N - 2)) begin
          j_n = j + CW'(1);
        end else if (pass == CW'(N - 2) || !(swp_pass || do_swap)) begin
          state_n  = S_DRAIN;
          rd_cnt_n = '0;
        end else begin
          pass_n     = pass + CW'(1);
          j_n        = '0;
          swp_pass_n = 1'b0;
        end
      end

      S_DRAIN: begin
        if (io.out_ready) begin
          rd_cnt_n = rd_cnt + CW'(1);
          if (rd_cnt == CW'(N - 1)) begin
            state_n = S_LOAD;
          end
        end
      end

      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      ld_cnt   <= '0;
      rd_cnt   <= '0;
      pass     <= '0;
      j        <= '0;
      swp_pass <= 1'b0;
      desc     <= ORD_ASC;
      swap_cnt <= '0;
      for (int unsigned i = 0; i < unsigned'(N); i++) begin
        mem[i] <= '0;
      end
    end else begin
      state    <= state_n;
      ld_cnt   <= ld_cnt_n;
      rd_cnt   <= rd_cnt_n;
      pass     <= pass_n;
      j        <= j_n;
      swp_pass <= swp_pass_n;
      desc     <= desc_n;
      swap_cnt <= swap_cnt_n;
      mem      <= mem_n;
    end
  end
endmodule
